// File: rtl/mult_ctrl_pkg.sv
// Shared types for the shift-add multiplier sequencer: FSM state encoding
// and the default multiplier width.
package mult_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    TEST = 3'd2,
    ADDS = 3'd3,
    SHFT = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/mult_ctrl_if.sv
// Start/done handshake plus datapath strobes between the multiplier sequencer
// (master) and its client and regs block (slave).
interface mult_ctrl_if;

  logic start;
  logic lsb;
  logic LOAD;
  logic ADD;
  logic SHIFT;
  logic busy;
  logic done;

  modport master (
    input  start, lsb,
    output LOAD, ADD, SHIFT, busy, done
  );

  modport slave (
    output start, lsb,
    input  LOAD, ADD, SHIFT, busy, done
  );

endinterface

// File: rtl/mult_ctrl.sv
// Sequencer for the shift-add multiplier: loads the multiplier, then runs N
// test/add/shift steps steered by register[0] and pulses done at the end.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  mult_ctrl_if.master bus
);

  localparam int              CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bus.LOAD  = 1'b0;
    bus.ADD   = 1'b0;
    bus.SHIFT = 1'b0;
    bus.busy  = 1'b1;
    bus.done  = 1'b0;

    // Outputs depend on state_q alone; inputs only steer state_d/count_d.
    case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        bus.LOAD = 1'b1;
        count_d  = '0;
        state_d  = TEST;
      end
      TEST: begin
        state_d = bus.lsb ? ADDS : SHFT;
      end
      ADDS: begin
        bus.ADD = 1'b1;
        state_d = SHFT;
      end
      SHFT: begin
        bus.SHIFT = 1'b1;
        if (count_q == LAST) begin
          state_d = DONE;
        end else begin
          count_d = count_q + CW'(1);
          state_d = TEST;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        bus.busy = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

endmodule
